// File: rtl/ncpu32k_regf_wb_arb.sv
// Round-robin write-back arbiter for the single register-file write port, plus a
// per-register pending scoreboard so issue logic can stall on RAW hazards.
module ncpu32k_regf_wb_arb #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_set_addr,
  input  logic                 flush,
  input  logic [AW-1:0]        rs1_addr,
  input  logic [AW-1:0]        rs2_addr,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 regf_we,
  output logic [AW-1:0]        regf_din_addr,
  output logic [DW-1:0]        regf_din
);

  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREG = 1 << AW;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            found;
  logic            xfer;
  logic [AW-1:0]   addr_sel;
  logic [DW-1:0]   data_sel;

  logic            regf_we_q, regf_we_d;
  logic [AW-1:0]   regf_din_addr_q, regf_din_addr_d;
  logic [DW-1:0]   regf_din_q, regf_din_d;
  logic [NREG-1:0] pending_q, pending_d;

  // Two passes: indices at/after rr_ptr first, then the wrapped-around lower indices.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!found && req_valid[i] && (PW'(unsigned'(i)) >= rr_ptr_q)) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = PW'(unsigned'(i));
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!found && req_valid[i]) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = PW'(unsigned'(i));
      end
    end
  end

  assign req_ready = grant;
  assign xfer      = |(req_valid & grant);

  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) begin
        addr_sel = req_addr[i*AW +: AW];
        data_sel = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    regf_we_d       = 1'b0;
    regf_din_addr_d = regf_din_addr_q;
    regf_din_d      = regf_din_q;
    if (xfer) begin
      rr_ptr_d        = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      regf_we_d       = (addr_sel != '0);
      regf_din_addr_d = addr_sel;
      regf_din_d      = data_sel;
    end
  end

  // Set is applied after clear so a newly issued producer keeps the register pending.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (xfer && (addr_sel != '0)) pending_d[addr_sel] = 1'b0;
      if (sb_set && (sb_set_addr != '0)) pending_d[sb_set_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q        <= '0;
      regf_we_q       <= 1'b0;
      regf_din_addr_q <= '0;
      regf_din_q      <= '0;
      pending_q       <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      regf_we_q       <= regf_we_d;
      regf_din_addr_q <= regf_din_addr_d;
      regf_din_q      <= regf_din_d;
      pending_q       <= pending_d;
    end
  end

  assign regf_we       = regf_we_q;
  assign regf_din_addr = regf_din_addr_q;
  assign regf_din      = regf_din_q;
  assign rs1_busy      = pending_q[rs1_addr];
  assign rs2_busy      = pending_q[rs2_addr];

endmodule

// File: tb/tb_ncpu32k_regf_wb_arb.sv
// Directed bench for the write-back arbiter: grant order, write port latency,
// scoreboard set/clear/flush and asynchronous reset.
module tb_ncpu32k_regf_wb_arb;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic                sb_set;
  logic [AW-1:0]       sb_set_addr;
  logic                flush;
  logic [AW-1:0]       rs1_addr;
  logic [AW-1:0]       rs2_addr;
  logic                rs1_busy;
  logic                rs2_busy;
  logic                regf_we;
  logic [AW-1:0]       regf_din_addr;
  logic [DW-1:0]       regf_din;

  int checks   = 0;
  int failures = 0;

  ncpu32k_regf_wb_arb #(
    .NREQ(NREQ),
    .AW  (AW),
    .DW  (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .sb_set       (sb_set),
    .sb_set_addr  (sb_set_addr),
    .flush        (flush),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .regf_we      (regf_we),
    .regf_din_addr(regf_din_addr),
    .regf_din     (regf_din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    sb_set      = 1'b0;
    sb_set_addr = '0;
    flush       = 1'b0;
    rs1_addr    = '0;
    rs2_addr    = '0;

    // Reset values
    #12;
    chk("rst_we", regf_we, 0);
    chk("rst_addr", regf_din_addr, 0);
    chk("rst_din", regf_din, 0);
    chk("rst_rs1_busy", rs1_busy, 0);
    chk("rst_ready", req_ready, 0);
    rst_n = 1'b1;
    tick();

    // 1: set pending on r5, then retire it through requester 0
    sb_set = 1'b1; sb_set_addr = 5; rs1_addr = 5;
    tick();
    sb_set = 1'b0;
    chk("t1_busy_set", rs1_busy, 1);
    set_req(0, 5, 32'hDEADBEEF);
    req_valid = 3'b001;
    #1;
    chk("t1_ready", req_ready, 3'b001);
    chk("t1_busy_hold", rs1_busy, 1);
    tick();
    req_valid = '0;
    chk("t1_we", regf_we, 1);
    chk("t1_addr", regf_din_addr, 5);
    chk("t1_din", regf_din, 32'hDEADBEEF);
    chk("t1_busy_clr", rs1_busy, 0);

    // rr_ptr is now 1; a lone requester 2 brings it back to 0
    set_req(0, 10, 32'h100);
    set_req(1, 11, 32'h101);
    set_req(2, 12, 32'h102);
    req_valid = 3'b100;
    #1;
    chk("t2_pre_ready", req_ready, 3'b100);
    tick();

    // 2: all requesters continuously valid
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t2_ready_%0d", k), req_ready, 3'b001 << (k % 3));
      tick();
      chk($sformatf("t2_we_%0d", k), regf_we, 1);
      chk($sformatf("t2_addr_%0d", k), regf_din_addr, 10 + (k % 3));
      chk($sformatf("t2_din_%0d", k), regf_din, 32'h100 + (k % 3));
    end
    req_valid = '0;

    // 3: requester 1 alone moves rr_ptr to 2, then 1 and 2 compete
    req_valid = 3'b010;
    tick();
    req_valid = 3'b110;
    #1;
    chk("t3_ready_first", req_ready, 3'b100);
    tick();
    chk("t3_addr_first", regf_din_addr, 12);
    req_valid = 3'b010;
    #1;
    chk("t3_ready_second", req_ready, 3'b010);
    tick();
    req_valid = '0;
    chk("t3_addr_second", regf_din_addr, 11);
    chk("t3_we_second", regf_we, 1);

    // 4: write to r0 is consumed but never written (rr_ptr=2, requester 0 wraps in)
    set_req(0, 0, 32'h1234);
    rs1_addr  = 0;
    req_valid = 3'b001;
    #1;
    chk("t4_ready", req_ready, 3'b001);
    chk("t4_busy0_a", rs1_busy, 0);
    tick();
    req_valid = '0;
    chk("t4_we", regf_we, 0);
    chk("t4_busy0_b", rs1_busy, 0);

    // 5: set and clear of r7 in the same cycle, set wins (rr_ptr=1)
    set_req(1, 7, 32'h77);
    rs2_addr    = 7;
    req_valid   = 3'b010;
    sb_set      = 1'b1;
    sb_set_addr = 7;
    #1;
    chk("t5_ready", req_ready, 3'b010);
    tick();
    req_valid = '0;
    sb_set    = 1'b0;
    chk("t5_we", regf_we, 1);
    chk("t5_addr", regf_din_addr, 7);
    chk("t5_din", regf_din, 32'h77);
    chk("t5_busy7", rs2_busy, 1);

    // 6a: flush clears several pending bits
    sb_set = 1'b1;
    sb_set_addr = 3; tick();
    sb_set_addr = 4; tick();
    sb_set_addr = 9; tick();
    sb_set = 1'b0;
    rs1_addr = 3; rs2_addr = 4;
    #1;
    chk("t6_busy3", rs1_busy, 1);
    chk("t6_busy4", rs2_busy, 1);
    rs1_addr = 9;
    #1;
    chk("t6_busy9", rs1_busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_flush9", rs1_busy, 0);
    chk("t6_flush7", rs2_busy, 0);
    rs1_addr = 3; rs2_addr = 4;
    #1;
    chk("t6_flush3", rs1_busy, 0);
    chk("t6_flush4", rs2_busy, 0);

    // 6b: transfer during flush still writes; sb_set in flush cycle ignored (rr_ptr=2)
    sb_set = 1'b1; sb_set_addr = 9;
    tick();
    sb_set_addr = 12;
    rs1_addr    = 9;
    rs2_addr    = 12;
    set_req(0, 9, 32'h99);
    req_valid = 3'b001;
    flush     = 1'b1;
    #1;
    chk("t6b_ready", req_ready, 3'b001);
    tick();
    flush     = 1'b0;
    sb_set    = 1'b0;
    req_valid = '0;
    chk("t6b_we", regf_we, 1);
    chk("t6b_addr", regf_din_addr, 9);
    chk("t6b_din", regf_din, 32'h99);
    chk("t6b_busy9", rs1_busy, 0);
    chk("t6b_busy12", rs2_busy, 0);

    // 6c: asynchronous reset mid-stream (rr_ptr=1)
    set_req(0, 10, 32'h100);
    req_valid = 3'b111;
    #1;
    chk("t6c_ready_a", req_ready, 3'b010);
    tick();
    #1;
    chk("t6c_ready_b", req_ready, 3'b100);
    chk("t6c_we_pre", regf_we, 1);
    rst_n = 1'b0;
    #1;
    chk("t6c_we_rst", regf_we, 0);
    chk("t6c_addr_rst", regf_din_addr, 0);
    chk("t6c_din_rst", regf_din, 0);
    chk("t6c_ready_rst", req_ready, 3'b001);
    #2;
    rst_n = 1'b1;
    #1;
    chk("t6c_ready_post", req_ready, 3'b001);
    tick();
    req_valid = '0;
    chk("t6c_we_post", regf_we, 1);
    chk("t6c_addr_post", regf_din_addr, 10);
    tick();
    chk("t6c_we_idle", regf_we, 0);
    chk("t6c_addr_hold", regf_din_addr, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ncpu32k_regf_wb_arb.md
Name: ncpu32k_regf_wb_arb

Overview:
Write-back arbiter and scoreboard for the single write port of the CPU register file.
- Several execution units (ALU, LSU, MUL/DIV, ...) share one write port. This block grants them round-robin and drives a registered write port to the register file.
- It also keeps a per-register pending bit, so issue logic can stall on RAW hazards.
- It sits between the execute/write-back stages and the register file.

Parameters:
NREQ, 3, number of write-back requesters (2..8).
AW, 5, register address width (`NCPU_REG_AW).
DW, 32, data width (`NCPU_DW).

Ports:
clk  in  1  core clock.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  NREQ  per-requester write-back valid.
req_ready  out  NREQ  per-requester accept (grant).
req_addr  in  NREQ*AW  destination register; requester i occupies bits [i*AW +: AW].
req_data  in  NREQ*DW  write-back data; requester i occupies bits [i*DW +: DW].
sb_set  in  1  issue stage marks a destination register pending.
sb_set_addr  in  AW  register to mark pending.
flush  in  1  pipeline flush; clears the scoreboard.
rs1_addr  in  AW  operand 1 register to check.
rs2_addr  in  AW  operand 2 register to check.
rs1_busy  out  1  operand 1 has an outstanding write.
rs2_busy  out  1  operand 2 has an outstanding write.
regf_we  out  1  register-file write enable.
regf_din_addr  out  AW  register-file write address.
regf_din  out  DW  register-file write data.

Behaviour:
Reset (async, rst_n=0):
- regf_we=0, regf_din_addr=0, regf_din=0.
- Round-robin pointer rr_ptr=0.
- All pending bits 0, so rs1_busy=rs2_busy=0.

Arbitration:
- Combinational one-hot grant. Search starts at index rr_ptr and wraps modulo NREQ; the first i with req_valid[i]=1 is granted.
- req_ready = grant. A transfer occurs when req_valid[i] & req_ready[i].
- At most one transfer per cycle. With no valid requester, grant=0.
- A requester must hold valid/addr/data stable until accepted. req_ready depends on req_valid; requesters must not make valid depend on ready.
- rr_ptr update on a transfer from i: rr_ptr <= (i+1) mod NREQ. Otherwise rr_ptr holds.
- Any requester continuously valid is accepted within NREQ cycles.

Write port (latency 1):
- A transfer in cycle t produces regf_we=1, regf_din_addr=req_addr[i], regf_din=req_data[i] during cycle t+1.
- Register-file commit happens at the end of t+1. The register-file bypass makes the data readable in t+1.
- Transfer with addr 0: accepted and consumed (ready=1), but regf_we stays 0 in t+1.
- No transfer in cycle t: regf_we=0 in t+1. Address and data hold their last values.

Scoreboard (2^AW bits; bit 0 is hard-wired 0):
- sb_set=1 with sb_set_addr!=0: pending[sb_set_addr] <= 1.
- Transfer to addr a (a!=0): pending[a] <= 0 at the same edge that launches the registered write.
- Set and clear to the same address in the same cycle: set wins (a newer producer was issued).
- flush=1: all bits <= 0 at the next edge. sb_set in the same cycle is ignored.
- flush does not cancel a write already registered, and does not block arbitration in the flush cycle.
- rs1_busy = pending[rs1_addr]; rs2_busy = pending[rs2_addr]. Both come from registered state, with no combinational path from req_*.
- Address 0 always reads not busy.

Multiple requesters targeting the same register: the block does not reorder or check. Ordering is the issuer's responsibility.

Reset asserted mid-operation: outputs go to reset values immediately. Any accepted but uncommitted write is dropped.

Test Plan:
1. Reset, then sb_set addr 5 in cycle 0 → rs1_addr=5 gives rs1_busy=1 from cycle 1. Requester 0 valid with addr 5, data 0xDEADBEEF in cycle 2 → ready[0]=1 in cycle 2; in cycle 3 regf_we=1, addr 5, data 0xDEADBEEF, and rs1_busy=0.
2. All 3 requesters held valid continuously → grants 0,1,2,0,1,2 on consecutive cycles; regf_we=1 every cycle from the second cycle on.
3. Requesters 1 and 2 valid with rr_ptr=2 → requester 2 granted first, then requester 1; rr_ptr ends at 2.
4. Requester valid with addr 0, data 0x1234 → ready=1, and regf_we=0 the next cycle; rs1_addr=0 gives rs1_busy=0 throughout.
5. Same cycle: sb_set addr 7 and a transfer to addr 7 → pending[7]=1 afterwards and regf_we=1 for addr 7.
6. Pending set on regs 3, 4, 9, then flush → all busy=0 next cycle. Separately: a transfer in the flush cycle still produces regf_we=1 in the next cycle. Separately: rst_n pulsed low mid-stream → regf_we=0 immediately and rr_ptr=0.
